// File: rtl/hyper_pipeline_flow_ctrl.sv
// hyper_pipeline_flow_ctrl
// Valid/ready wrapper around a fixed-latency, non-stallable register pipeline.
// Beats leaving the last stage land in a circular skid FIFO. Upstream is
// credit-gated on (beats in stages + beats in FIFO), so every beat that enters
// the pipeline is guaranteed a FIFO slot when it comes out.
module hyper_pipeline_flow_ctrl #(
   parameter int STAGES     = 4,
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                            ap_clk,
   input  logic                            areset_n,
   input  logic                            flush,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [WIDTH-1:0]                s_data,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [WIDTH-1:0]                m_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] inflight_count,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
   output logic                            overflow_error
);

   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW:0]   L_DEPTH_EXT = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] L_DEPTH     = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] L_PTR_LAST  = PW'(FIFO_DEPTH-1);

   logic [CW-1:0]    r_inflight;
   logic [CW-1:0]    r_fifo_cnt;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic             r_overflow;
   logic [WIDTH-1:0] r_mem [FIFO_DEPTH];

   logic             w_accept;
   logic             w_pop;
   logic             w_wr;
   logic             w_wr_ok;
   logic             w_full;
   logic [WIDTH-1:0] w_wr_data;
   logic [CW:0]      w_credit_used;

   // Circular pointer advance; depth need not be a power of two.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == L_PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Up/down counter step; simultaneous inc and dec cancel.
   function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] c,
                                              input logic inc,
                                              input logic dec);
      logic [CW-1:0] r;
      r = c;
      if (inc && !dec) r = c + 1'b1;
      if (dec && !inc) r = c - 1'b1;
      return r;
   endfunction

   // Credit check uses registered counts only, so m_ready never reaches s_ready.
   assign w_credit_used = {1'b0, r_inflight} + {1'b0, r_fifo_cnt};
   assign s_ready       = areset_n & ~flush & (w_credit_used < L_DEPTH_EXT);
   assign m_valid       = areset_n & ~flush & (r_fifo_cnt != '0);
   assign m_data        = m_valid ? r_mem[r_rd_ptr] : '0;
   assign w_accept      = s_valid & s_ready;
   assign w_pop         = m_valid & m_ready;
   assign w_full        = (r_fifo_cnt == L_DEPTH);
   assign w_wr_ok       = w_wr & ~w_full & ~flush;

   assign inflight_count = r_inflight;
   assign fifo_count     = r_fifo_cnt;
   assign overflow_error = r_overflow;

   generate
      if (STAGES == 0) begin : g_direct
         // No register stages: accepted beats go straight into the FIFO.
         assign w_wr      = w_accept;
         assign w_wr_data = s_data;
      end else begin : g_pipe
         logic [STAGES-1:0] r_vld_p;
         logic [WIDTH-1:0]  r_dat_p [STAGES];

         // Stage valid bits: cleared by reset and flush, shifted every cycle.
         always_ff @(posedge ap_clk or negedge areset_n) begin
            if (!areset_n) begin
               r_vld_p <= '0;
            end else if (flush) begin
               r_vld_p <= '0;
            end else begin
               r_vld_p[0] <= w_accept;
               for (int i = 1; i < STAGES; i++) begin
                  r_vld_p[i] <= r_vld_p[i-1];
               end
            end
         end

         // Stage data: free-running shift, meaningful only where valid is set.
         always_ff @(posedge ap_clk) begin
            r_dat_p[0] <= s_data;
            for (int i = 1; i < STAGES; i++) begin
               r_dat_p[i] <= r_dat_p[i-1];
            end
         end

         assign w_wr      = r_vld_p[STAGES-1];
         assign w_wr_data = r_dat_p[STAGES-1];
      end
   endgenerate

   // Counts and FIFO pointers; flush discards everything held or in flight.
   always_ff @(posedge ap_clk or negedge areset_n) begin
      if (!areset_n) begin
         r_inflight <= '0;
         r_fifo_cnt <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else if (flush) begin
         r_inflight <= '0;
         r_fifo_cnt <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         r_inflight <= cnt_step(r_inflight, w_accept, w_wr);
         r_fifo_cnt <= cnt_step(r_fifo_cnt, w_wr_ok, w_pop);
         if (w_wr_ok) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_pop)   r_rd_ptr <= next_ptr(r_rd_ptr);
      end
   end

   // Sticky flag for a pipeline write meeting a full FIFO (credit broken).
   always_ff @(posedge ap_clk or negedge areset_n) begin
      if (!areset_n) begin
         r_overflow <= 1'b0;
      end else if (w_wr && w_full && !flush) begin
         r_overflow <= 1'b1;
      end
   end

   // FIFO storage write; storage itself is never reset.
   always_ff @(posedge ap_clk) begin
      if (w_wr_ok) r_mem[r_wr_ptr] <= w_wr_data;
   end

endmodule

// File: tb/tb_hyper_pipeline_flow_ctrl.sv
// Bench for hyper_pipeline_flow_ctrl: three instances (4/8, 0/3, 7/5 stages/depth)
// checked every cycle against a queue model where a beat accepted in cycle c
// becomes visible at the output from cycle c+STAGES+1 onward.
module tb_hyper_pipeline_flow_ctrl;
   localparam int N = 3;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sv [N];
   logic sr [N];
   logic mv [N];
   logic mr [N];
   logic fl [N];
   logic ov [N];
   logic [W-1:0] sd [N];
   logic [W-1:0] md [N];
   logic [3:0] ic [N];
   logic [3:0] fc [N];
   logic [3:0] ic0, fc0;
   logic [1:0] ic1, fc1;
   logic [2:0] ic2, fc2;

   assign ic[0] = ic0;
   assign fc[0] = fc0;
   assign ic[1] = {2'b00, ic1};
   assign fc[1] = {2'b00, fc1};
   assign ic[2] = {1'b0, ic2};
   assign fc[2] = {1'b0, fc2};

   hyper_pipeline_flow_ctrl #(.STAGES(4), .WIDTH(W), .FIFO_DEPTH(8)) u_dut0 (
      .ap_clk(clk), .areset_n(rst_n), .flush(fl[0]), .s_valid(sv[0]), .s_ready(sr[0]),
      .s_data(sd[0]), .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]),
      .inflight_count(ic0), .fifo_count(fc0), .overflow_error(ov[0]));

   hyper_pipeline_flow_ctrl #(.STAGES(0), .WIDTH(W), .FIFO_DEPTH(3)) u_dut1 (
      .ap_clk(clk), .areset_n(rst_n), .flush(fl[1]), .s_valid(sv[1]), .s_ready(sr[1]),
      .s_data(sd[1]), .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]),
      .inflight_count(ic1), .fifo_count(fc1), .overflow_error(ov[1]));

   hyper_pipeline_flow_ctrl #(.STAGES(7), .WIDTH(W), .FIFO_DEPTH(5)) u_dut2 (
      .ap_clk(clk), .areset_n(rst_n), .flush(fl[2]), .s_valid(sv[2]), .s_ready(sr[2]),
      .s_data(sd[2]), .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md[2]),
      .inflight_count(ic2), .fifo_count(fc2), .overflow_error(ov[2]));

   always #5 clk = ~clk;

   // model state: beats held (accepted, not yet popped) with their accept cycle
   logic [W-1:0] q_d [N][$];
   int           q_t [N][$];
   int           cyc;
   int           n_chk;
   int           n_pass;

   logic         e_sr [N];
   logic         e_mv [N];
   logic [W-1:0] e_md [N];
   int           e_ic [N];
   int           e_fc [N];
   logic         m_acc [N];
   logic         m_pop [N];

   // last observed DUT values and observed output stream
   logic         lo_sr [N];
   logic         lo_mv [N];
   logic [3:0]   lo_ic [N];
   logic [3:0]   lo_fc [N];
   logic [W-1:0] outq [N][$];
   int           outc [N][$];

   function automatic int stg(input int k);
      case (k)
         0:       return 4;
         1:       return 0;
         default: return 7;
      endcase
   endfunction

   function automatic int dep(input int k);
      case (k)
         0:       return 8;
         1:       return 3;
         default: return 5;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic model_outputs(input int k);
      int vis;
      vis = 0;
      for (int i = 0; i < q_t[k].size(); i++) begin
         if (cyc >= q_t[k][i] + stg(k) + 1) vis++;
      end
      if (!rst_n) begin
         e_sr[k] = 1'b0;
         e_mv[k] = 1'b0;
         e_md[k] = '0;
         e_ic[k] = 0;
         e_fc[k] = 0;
      end else begin
         e_fc[k] = vis;
         e_ic[k] = q_t[k].size() - vis;
         e_sr[k] = !fl[k] && (q_t[k].size() < dep(k));
         e_mv[k] = !fl[k] && (vis > 0);
         e_md[k] = e_mv[k] ? q_d[k][0] : '0;
      end
   endtask

   // one clock cycle: compare at negedge, advance model at posedge, return at posedge+1
   task automatic step();
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         model_outputs(k);
         check($sformatf("d%0d_s_ready", k), 32'(sr[k]), 32'(e_sr[k]));
         check($sformatf("d%0d_m_valid", k), 32'(mv[k]), 32'(e_mv[k]));
         check($sformatf("d%0d_m_data", k), md[k], e_md[k]);
         check($sformatf("d%0d_inflight", k), 32'(ic[k]), 32'(e_ic[k]));
         check($sformatf("d%0d_fifo_count", k), 32'(fc[k]), 32'(e_fc[k]));
         check($sformatf("d%0d_overflow", k), 32'(ov[k]), 32'd0);
         check($sformatf("d%0d_credit", k),
               32'((32'(ic[k]) + 32'(fc[k])) <= 32'(dep(k))), 32'd1);
         lo_sr[k] = sr[k];
         lo_mv[k] = mv[k];
         lo_ic[k] = ic[k];
         lo_fc[k] = fc[k];
         m_acc[k] = e_sr[k] & sv[k];
         m_pop[k] = e_mv[k] & mr[k];
         if (mv[k] && mr[k]) begin
            outq[k].push_back(md[k]);
            outc[k].push_back(cyc);
         end
      end
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
         if (!rst_n || fl[k]) begin
            q_d[k].delete();
            q_t[k].delete();
         end else begin
            if (m_pop[k]) begin
               void'(q_d[k].pop_front());
               void'(q_t[k].pop_front());
            end
            if (m_acc[k]) begin
               q_d[k].push_back(sd[k]);
               q_t[k].push_back(cyc);
            end
         end
      end
      cyc++;
      #1;
   endtask

   task automatic clear_out(input int k);
      outq[k].delete();
      outc[k].delete();
   endtask

   initial begin
      int v;
      int low;
      int start;
      n_chk = 0;
      n_pass = 0;
      cyc = 0;
      for (int k = 0; k < N; k++) begin
         sv[k] = 1'b0; mr[k] = 1'b0; fl[k] = 1'b0; sd[k] = '0;
      end

      // reset held for two cycles, then released
      step();
      step();
      rst_n = 1'b1;
      step();
      check("post_reset_s_ready", 32'(lo_sr[0]), 32'd1);

      // single beat latency
      clear_out(0);
      mr[0] = 1'b1;
      sv[0] = 1'b1;
      sd[0] = 32'hA5;
      start = cyc;
      step();
      sv[0] = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("single_count", 32'(outq[0].size()), 32'd1);
      if (outq[0].size() == 1) begin
         check("single_data", outq[0][0], 32'hA5);
         check("single_latency", 32'(outc[0][0] - start), 32'd5);
      end
      check("single_inflight_end", 32'(lo_ic[0]), 32'd0);
      check("single_fifo_end", 32'(lo_fc[0]), 32'd0);

      // backpressure: fill credit, then drain in order
      clear_out(0);
      mr[0] = 1'b0;
      v = 0;
      sv[0] = 1'b1;
      sd[0] = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (lo_sr[0]) begin v++; sd[0] = v; end
      end
      check("bp_accepted", 32'(v), 32'd8);
      check("bp_s_ready_low", 32'(lo_sr[0]), 32'd0);
      check("bp_fifo_full", 32'(lo_fc[0]), 32'd8);
      check("bp_inflight_zero", 32'(lo_ic[0]), 32'd0);
      mr[0] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (sv[0] && lo_sr[0]) begin
            v++;
            if (v == 12) sv[0] = 1'b0;
            else sd[0] = v;
         end
      end
      check("bp_out_count", 32'(outq[0].size()), 32'd12);
      for (int i = 0; i < outq[0].size(); i++) check($sformatf("bp_out%0d", i), outq[0][i], 32'(i));
      check("bp_overflow", 32'(ov[0]), 32'd0);

      // throughput: 100 back-to-back beats
      clear_out(0);
      mr[0] = 1'b1;
      v = 0;
      low = 0;
      sv[0] = 1'b1;
      sd[0] = 1000;
      start = cyc;
      for (int i = 0; i < 200 && v < 100; i++) begin
         step();
         if (!lo_sr[0]) low++;
         else begin
            v++;
            sd[0] = 1000 + v;
            if (v == 100) sv[0] = 1'b0;
         end
      end
      for (int i = 0; i < 10; i++) step();
      check("tp_s_ready_drops", 32'(low), 32'd0);
      check("tp_out_count", 32'(outq[0].size()), 32'd100);
      if (outq[0].size() == 100) begin
         check("tp_first_latency", 32'(outc[0][0] - start), 32'd5);
         check("tp_consecutive", 32'(outc[0][99] - outc[0][0]), 32'd99);
         v = 0;
         for (int i = 0; i < 100; i++) if (outq[0][i] != 32'(1000 + i)) v++;
         check("tp_order_errors", 32'(v), 32'd0);
      end

      // flush with 3 beats in flight and 2 in the FIFO
      mr[0] = 1'b0;
      sv[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sd[0] = 32'h40 + i;
         step();
      end
      sv[0] = 1'b0;
      step();
      fl[0] = 1'b1;
      step();
      check("fl_s_ready", 32'(lo_sr[0]), 32'd0);
      check("fl_m_valid", 32'(lo_mv[0]), 32'd0);
      check("fl_inflight_before", 32'(lo_ic[0]), 32'd3);
      check("fl_fifo_before", 32'(lo_fc[0]), 32'd2);
      fl[0] = 1'b0;
      mr[0] = 1'b1;
      clear_out(0);
      step();
      check("fl_inflight_after", 32'(lo_ic[0]), 32'd0);
      check("fl_fifo_after", 32'(lo_fc[0]), 32'd0);
      check("fl_s_ready_after", 32'(lo_sr[0]), 32'd1);
      for (int i = 0; i < 9; i++) step();
      check("fl_no_stale", 32'(outq[0].size()), 32'd0);
      start = cyc;
      sv[0] = 1'b1;
      sd[0] = 32'h77;
      step();
      sv[0] = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("fl_new_count", 32'(outq[0].size()), 32'd1);
      if (outq[0].size() == 1) begin
         check("fl_new_data", outq[0][0], 32'h77);
         check("fl_new_latency", 32'(outc[0][0] - start), 32'd5);
      end

      // asynchronous reset mid-stream
      mr[0] = 1'b0;
      sv[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         sd[0] = 32'h500 + i;
         step();
      end
      sv[0] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < N; k++) begin
         check($sformatf("ar%0d_s_ready", k), 32'(sr[k]), 32'd0);
         check($sformatf("ar%0d_m_valid", k), 32'(mv[k]), 32'd0);
         check($sformatf("ar%0d_m_data", k), md[k], 32'd0);
         check($sformatf("ar%0d_inflight", k), 32'(ic[k]), 32'd0);
         check($sformatf("ar%0d_fifo", k), 32'(fc[k]), 32'd0);
      end
      step();
      step();
      rst_n = 1'b1;
      clear_out(0);
      step();
      check("ar_s_ready_release", 32'(lo_sr[0]), 32'd1);
      mr[0] = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("ar_no_stale", 32'(outq[0].size()), 32'd0);

      // random stress on all three instances
      for (int i = 0; i < 10000; i++) begin
         for (int k = 0; k < N; k++) begin
            sv[k] = ($urandom_range(0, 3) != 0);
            sd[k] = $urandom;
            if (i < 5000) mr[k] = ($urandom_range(0, 2) != 0);
            else          mr[k] = ($urandom_range(0, 3) == 0);
            fl[k] = ($urandom_range(0, 63) == 0);
         end
         step();
      end
      for (int k = 0; k < N; k++) begin
         sv[k] = 1'b0; fl[k] = 1'b0; mr[k] = 1'b1;
      end
      for (int i = 0; i < 15; i++) step();
      for (int k = 0; k < N; k++) begin
         check($sformatf("rs%0d_drained", k), 32'(fc[k]) + 32'(ic[k]), 32'd0);
         check($sformatf("rs%0d_overflow", k), 32'(ov[k]), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
